tb_obi_mem_responder: RTL and testbench

Parametrised OBI slave memory model for core-level testbenches. It succeeds the fixed single-cycle RAM responder and adds configurable depth, data width, pipelined outstanding transactions, a minimum response latency, LFSR-driven random grant stalls and error responses for out-of-range accesses. It also decodes a memory-mapped exit register that drives the bench pass/fail/exit outputs. One instance serves one OBI port, either instruction or data.

---
 rtl/tb_obi_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_tb_obi_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_obi_mem_responder.sv
// OBI slave memory model for core-level benches: in-order pipelined responses with a
// minimum latency, LFSR-driven grant stalls, range errors and a sticky exit register.
module tb_obi_mem_responder #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter logic [31:0] EXIT_ADDR       = 32'h2000_0004
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rand_stall_en_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [31:0]             addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    exit_valid_o,
    output logic [31:0]             exit_value_o,
    output logic                    tests_passed_o,
    output logic                    tests_failed_o
);
    localparam int NB    = int'(DATA_WIDTH / 8);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int LAT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RESP_LATENCY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    logic [DATA_WIDTH-1:0] fifoData_q [MAX_OUTSTANDING];
    logic                  fifoErr_q  [MAX_OUTSTANDING];
    logic [LAT_W-1:0]      fifoLat_q  [MAX_OUTSTANDING];

    logic [15:0]           lfsr_q, lfsr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic                  rvalid_q, err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  exitValid_q, passed_q, failed_q;
    logic [31:0]           exitValue_q;

    logic                  stall, accept, pop;
    logic                  isExit, inRange, isErr;
    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [DATA_WIDTH-1:0] pushData;
    logic [31:0]           wdata32;
    logic                  unusedAddrLsbs;

    assign unusedAddrLsbs = ^addr_i[1:0];
    assign wdata32        = 32'(wdata_i);

    assign stall   = rand_stall_en_i & lfsr_q[0];
    assign gnt_o   = req_i & ~stall & (count_q < CNT_MAX);
    assign accept  = req_i & gnt_o;
    assign isExit  = (addr_i[31:2] == EXIT_ADDR[31:2]);
    assign inRange = (addr_i[31:ADDR_WIDTH+2] == '0);
    assign isErr   = !isExit && !inRange;
    assign wordIdx = addr_i[ADDR_WIDTH+1:2];
    // Entries are always pushed at an earlier edge, so a zero head counter implies residency.
    assign pop     = (count_q != '0) && (fifoLat_q[rdPtr_q] == '0);

    always_comb begin
        pushData = '0;
        if (!we_i) begin
            if (isExit) begin
                pushData = DATA_WIDTH'(exitValue_q);
            end else if (inRange) begin
                pushData = mem_q[wordIdx];
            end
        end
    end

    always_comb begin
        lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        count_d = count_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (accept) begin
            wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q      <= LFSR_SEED;
            count_q     <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            exitValid_q <= 1'b0;
            exitValue_q <= '0;
            passed_q    <= 1'b0;
            failed_q    <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            count_q  <= count_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            rvalid_q <= pop;
            rdata_q  <= pop ? fifoData_q[rdPtr_q] : '0;
            err_q    <= pop & fifoErr_q[rdPtr_q];
            // Only the first exit write after reset is latched.
            if (accept && we_i && isExit && !exitValid_q) begin
                exitValid_q <= 1'b1;
                exitValue_q <= wdata32;
                passed_q    <= (wdata32 == 32'h0);
                failed_q    <= (wdata32 != 32'h0);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (fifoLat_q[i] != '0) begin
                fifoLat_q[i] <= fifoLat_q[i] - LAT_W'(1);
            end
        end
        if (accept) begin
            fifoData_q[wrPtr_q] <= pushData;
            fifoErr_q[wrPtr_q]  <= isErr;
            fifoLat_q[wrPtr_q]  <= LAT_INIT;
        end
    end

    // Memory is deliberately left out of reset so contents survive a bench reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && accept && we_i && !isExit && inRange) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[wordIdx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rvalid_o       = rvalid_q;
    assign rdata_o        = rdata_q;
    assign err_o          = err_q;
    assign exit_valid_o   = exitValid_q;
    assign exit_value_o   = exitValue_q;
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;

endmodule

// File: tb/tb_tb_obi_mem_responder.sv
// Scoreboard bench: three responder instances (latency 1, backpressure, stalls/reset)
// checked against a transaction-level model of memory, exit register, grants and timing.
`timescale 1ns/1ps
module tb_tb_obi_mem_responder;
    localparam logic [31:0] EXIT_ADDR = 32'h2000_0004;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          AW        = 16;

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic        err;
        int          cycle;
    } exp_t;

    logic             clk;
    logic [2:0]       rst, stallEn, req, we;
    logic [2:0][31:0] addr, wdata;
    logic [2:0][3:0]  be;
    wire  [2:0]       gnt, rvalid, err, exitValid, passed, failed;
    wire  [2:0][31:0] rdata, exitValue;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          monitorOn = 0;
    exp_t        expQ[$];
    logic [31:0] refMem [int];
    logic [15:0] refLfsr [3];
    bit          refExitValid [3];
    logic [31:0] refExitValue [3];

    // Instance 0: latency 1; instance 1: two slots, latency 4; instance 2: four slots, latency 4.
    for (genvar g = 0; g < 3; g++) begin : gInst
        tb_obi_mem_responder #(
            .ADDR_WIDTH(AW),
            .DATA_WIDTH(32),
            .MAX_OUTSTANDING((g == 1) ? 2 : 4),
            .RESP_LATENCY((g == 0) ? 1 : 4),
            .LFSR_SEED(SEED),
            .EXIT_ADDR(EXIT_ADDR)
        ) dut (
            .clk_i(clk),
            .rst_i(rst[g]),
            .rand_stall_en_i(stallEn[g]),
            .req_i(req[g]),
            .gnt_o(gnt[g]),
            .addr_i(addr[g]),
            .we_i(we[g]),
            .be_i(be[g]),
            .wdata_i(wdata[g]),
            .rvalid_o(rvalid[g]),
            .rdata_o(rdata[g]),
            .err_o(err[g]),
            .exit_valid_o(exitValid[g]),
            .exit_value_o(exitValue[g]),
            .tests_passed_o(passed[g]),
            .tests_failed_o(failed[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int maxOf(input int g);
        return (g == 1) ? 2 : 4;
    endfunction

    function automatic int latOf(input int g);
        return (g == 0) ? 1 : 4;
    endfunction

    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        logic [15:0] fb;
        fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h1;
        return (s >> 1) | (fb << 15);
    endfunction

    function automatic int pendingCount(input int g);
        int n;
        n = 0;
        foreach (expQ[i]) if (expQ[i].inst == g) n++;
        return n;
    endfunction

    // Reference stall generator, one per instance, restarted from the seed on reset.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            refLfsr[g] <= rst[g] ? SEED : lfsrNext(refLfsr[g]);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkExit(input int g);
        checkOutput($sformatf("exit_valid_inst%0d", g), 32'(exitValid[g]), 32'(refExitValid[g]));
        checkOutput($sformatf("exit_value_inst%0d", g), exitValue[g],
                    refExitValid[g] ? refExitValue[g] : 32'h0);
        checkOutput($sformatf("tests_passed_inst%0d", g), 32'(passed[g]),
                    32'(refExitValid[g] && refExitValue[g] == 32'h0));
        checkOutput($sformatf("tests_failed_inst%0d", g), 32'(failed[g]),
                    32'(refExitValid[g] && refExitValue[g] != 32'h0));
    endtask

    // Drive one request until granted, checking every cycle's grant, then log the response.
    task automatic applyStimulus(input int g, input logic w, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] d);
        bit          granted;
        int          waited;
        logic        expGnt;
        exp_t        e;
        logic [31:0] word;
        int          key;
        granted = 0;
        waited  = 0;
        while (!granted) begin
            @(negedge clk);
            req[g] = 1'b1; we[g] = w; addr[g] = a; be[g] = b; wdata[g] = d;
            #1;
            expGnt = !(stallEn[g] && refLfsr[g][0]) && (pendingCount(g) < maxOf(g));
            checkOutput($sformatf("gnt_inst%0d", g), 32'(gnt[g]), 32'(expGnt));
            if (gnt[g]) begin
                granted = 1;
            end else if (++waited >= 100) begin
                checks++;
                errors++;
                $display("[TB] FAIL grant_timeout_inst%0d: got no grant in 100 cycles, expected a grant", g);
                req[g] = 1'b0;
                return;
            end
        end
        e.inst  = g;
        e.data  = 32'h0;
        e.err   = 1'b0;
        e.cycle = cyc + latOf(g) + 1;
        if ((a & ~32'h3) == (EXIT_ADDR & ~32'h3)) begin
            if (w) begin
                if (!refExitValid[g]) begin
                    refExitValid[g] = 1;
                    refExitValue[g] = d;
                end
            end else begin
                e.data = refExitValue[g];
            end
        end else if (a < (32'h1 << (AW + 2))) begin
            key = g * 65536 + int'(a >> 2);
            if (w) begin
                word = refMem.exists(key) ? refMem[key] : 32'h0;
                for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
                refMem[key] = word;
            end else begin
                e.data = refMem[key];
            end
        end else begin
            e.err = 1'b1;
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        req[g] = 1'b0;
    endtask

    task automatic resetInst(input int g);
        @(negedge clk);
        rst[g] = 1'b1;
        req[g] = 1'b0;
        #1;
        for (int i = expQ.size() - 1; i >= 0; i--) if (expQ[i].inst == g) expQ.delete(i);
        refExitValid[g] = 0;
        refExitValue[g] = 32'h0;
        @(negedge clk);
        rst[g] = 1'b0;
        #1;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (expQ.size() > 0 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d responses still pending, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Monitor: pops the scoreboard on every rvalid and checks data, error flag and cycle.
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            cyc++;
            if (monitorOn) begin
                for (int g = 0; g < 3; g++) begin
                    if (rvalid[g]) begin
                        idx = -1;
                        for (int i = 0; i < expQ.size(); i++) begin
                            if (idx < 0 && expQ[i].inst == g) idx = i;
                        end
                        if (idx < 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_rvalid_inst%0d: got rvalid=1, expected no response (cycle %0d)", g, cyc);
                        end else begin
                            checkOutput($sformatf("rdata_inst%0d", g), rdata[g], expQ[idx].data);
                            checkOutput($sformatf("err_inst%0d", g), 32'(err[g]), 32'(expQ[idx].err));
                            checkOutput($sformatf("resp_cycle_inst%0d", g), 32'(cyc), 32'(expQ[idx].cycle));
                            expQ.delete(idx);
                        end
                    end else begin
                        checkOutput($sformatf("idle_rdata_inst%0d", g), rdata[g], 32'h0);
                        checkOutput($sformatf("idle_err_inst%0d", g), 32'(err[g]), 32'h0);
                    end
                end
            end
        end
    end

    initial begin
        int          kind;
        logic [31:0] a;
        rst = '1; stallEn = '0; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        for (int g = 0; g < 3; g++) begin
            refExitValid[g] = 0;
            refExitValue[g] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst = '0;
        #1;
        monitorOn = 1;
        for (int g = 0; g < 3; g++) checkExit(g);

        $display("[TB] back-to-back write/read and byte enables");
        applyStimulus(0, 1'b1, 32'h100, 4'hF, 32'hCAFE_F00D);
        applyStimulus(0, 1'b0, 32'h100, 4'hF, 32'h0);
        applyStimulus(0, 1'b1, 32'h104, 4'hF, 32'h1122_3344);
        applyStimulus(0, 1'b1, 32'h104, 4'b0010, 32'hAABB_CCDD);
        applyStimulus(0, 1'b0, 32'h107, 4'hF, 32'h0);

        $display("[TB] out-of-range accesses");
        applyStimulus(0, 1'b1, 32'h0, 4'hF, 32'h1234_5678);
        applyStimulus(0, 1'b0, 32'h1 << (AW + 2), 4'hF, 32'h0);
        applyStimulus(0, 1'b1, 32'h1 << (AW + 2), 4'hF, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b0, 32'h0, 4'hF, 32'h0);

        $display("[TB] exit register");
        applyStimulus(0, 1'b1, EXIT_ADDR, 4'hF, 32'h0);
        checkExit(0);
        applyStimulus(0, 1'b1, EXIT_ADDR, 4'hF, 32'h5);
        checkExit(0);
        applyStimulus(0, 1'b0, EXIT_ADDR, 4'hF, 32'h0);
        drain();
        resetInst(0);
        checkExit(0);
        applyStimulus(0, 1'b1, EXIT_ADDR, 4'hF, 32'h5);
        checkExit(0);
        applyStimulus(0, 1'b0, 32'h100, 4'hF, 32'h0);
        drain();

        $display("[TB] backpressure with two slots");
        applyStimulus(1, 1'b1, 32'h0, 4'hF, 32'hA5A5_0001);
        applyStimulus(1, 1'b1, 32'h4, 4'hF, 32'h5A5A_0002);
        applyStimulus(1, 1'b0, 32'h0, 4'hF, 32'h0);
        applyStimulus(1, 1'b0, 32'h4, 4'hF, 32'h0);
        applyStimulus(1, 1'b0, 32'h2, 4'hF, 32'h0);
        drain();

        $display("[TB] random traffic with stalls");
        stallEn[2] = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(2, 1'b1, 32'h200 + 32'(i * 4), 4'hF, $urandom);
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 9));
            a = 32'h200 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
            if (kind <= 3) begin
                applyStimulus(2, 1'b1, a, 4'($urandom_range(1, 15)), $urandom);
            end else if (kind <= 7) begin
                applyStimulus(2, 1'b0, a, 4'hF, 32'h0);
            end else if (kind == 8) begin
                a = {14'($urandom_range(1, 16383)), 18'($urandom)};
                applyStimulus(2, 1'($urandom_range(0, 1)), a, 4'hF, $urandom);
            end else begin
                applyStimulus(2, 1'b0, EXIT_ADDR, 4'hF, 32'h0);
            end
        end
        drain();

        $display("[TB] reset with three responses in flight");
        stallEn[2] = 1'b0;
        applyStimulus(2, 1'b1, 32'h200, 4'hF, 32'h0BAD_0000);
        applyStimulus(2, 1'b0, 32'h204, 4'hF, 32'h0);
        applyStimulus(2, 1'b1, 32'h208, 4'b1001, 32'h7700_0077);
        resetInst(2);
        checkExit(2);
        repeat (8) @(negedge clk);
        stallEn[2] = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(2, 1'b0, 32'h200 + 32'(i * 4), 4'hF, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
